// File: rtl/reg_scan_ctrl.sv
// reg_scan_ctrl: sequences register select, read-latency wait, capture and display dwell; optional change flag via REG_SCAN_CHANGE_FLAG_EN
module reg_scan_ctrl #(
  parameter int NUM_REGS     = 8,
  parameter int IDX_W        = 3,
  parameter int DATA_W       = 16,
  parameter int READ_LAT     = 1,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              auto_en,
  input  logic [IDX_W-1:0]  man_sel,
  input  logic              step_n,
  input  logic              freeze,
  output logic [IDX_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] disp_data,
  output logic [IDX_W-1:0]  disp_idx,
  output logic              disp_valid,
  output logic              busy
`ifdef REG_SCAN_CHANGE_FLAG_EN
  , output logic            disp_changed
`endif
);
  localparam int MAXC = READ_LAT > DWELL_CYCLES ? READ_LAT : DWELL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [1:0] SEL = 2'd0, WAIT = 2'd1, CAP = 2'd2, DWELL = 2'd3;
  localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [CW-1:0] LAT_END = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] DW_END = CW'(DWELL_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] scan_q, scan_d, sel_q, sel_d, idx_q, idx_d, scan_inc, man_clamp;
  logic [DATA_W-1:0] data_q, data_d;
  logic mode_q, mode_d, valid_q, valid_d, busy_q, busy_d, prev_q, step_abort, cap_en;
  assign scan_inc = scan_q == LAST ? '0 : scan_q + 1'b1;
  assign man_clamp = {1'b0, man_sel} >= NR ? LAST : man_sel;
  // a step edge only counts in auto mode and never while frozen; it pre-empts the normal sequence
  assign step_abort = !freeze && auto_en && prev_q && !step_n;
  assign cap_en = !freeze && !step_abort && state_q == CAP;
  assign reg_sel = sel_q;
  assign disp_data = data_q;
  assign disp_idx = idx_q;
  assign disp_valid = valid_q;
  assign busy = busy_q;
  // next-state: freeze stalls everything, step aborts to SEL, otherwise walk SEL/WAIT/CAP/DWELL
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    scan_d = scan_q;
    sel_d = sel_q;
    mode_d = mode_q;
    data_d = data_q;
    idx_d = idx_q;
    valid_d = valid_q;
    if (step_abort) begin
      scan_d = scan_inc;
      state_d = SEL;
      cnt_d = '0;
    end else if (!freeze) begin
      case (state_q)
        SEL: begin
          sel_d = auto_en ? scan_q : man_clamp;
          mode_d = auto_en;
          state_d = WAIT;
          cnt_d = '0;
        end
        WAIT: begin
          state_d = cnt_q == LAT_END ? CAP : WAIT;
          cnt_d = cnt_q == LAT_END ? '0 : cnt_q + 1'b1;
        end
        CAP: begin
          data_d = reg_data;
          idx_d = sel_q;
          valid_d = 1'b1;
          state_d = DWELL;
          cnt_d = '0;
        end
        default: begin
          state_d = (!mode_q || cnt_q == DW_END) ? SEL : DWELL;
          cnt_d = (!mode_q || cnt_q == DW_END) ? '0 : cnt_q + 1'b1;
          scan_d = (mode_q && cnt_q == DW_END) ? scan_inc : scan_q;
        end
      endcase
    end
    busy_d = freeze ? busy_q : (state_d == SEL || state_d == WAIT);
  end
  // state registers; the step edge detector tracks the button even while frozen
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= SEL;
      cnt_q <= '0;
      scan_q <= '0;
      sel_q <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      scan_q <= scan_d;
      sel_q <= sel_d;
      mode_q <= mode_d;
      data_q <= data_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      prev_q <= step_n;
    end
  end
`ifdef REG_SCAN_CHANGE_FLAG_EN
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic chg_q;
  assign disp_changed = chg_q;
  // remember the last capture per index and pulse when a new capture differs from it
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      chg_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (!freeze) begin
      chg_q <= cap_en && reg_data != shadow_q[sel_q];
      if (cap_en) shadow_q[sel_q] <= reg_data;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = cap_en;
`endif
endmodule
